// File: rtl/z80_block_xfer_seq_if.sv
// Memory bus between the block-transfer sequencer (master) and memory (slave).
interface z80_block_xfer_seq_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_wait;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_wait
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata,
        output mem_wait
    );
endinterface

// File: rtl/z80_block_xfer_seq.sv
// Z80 LDI/LDD/LDIR/LDDR execution sequencer: read, write, 2 extended T-states, optional repeat.
// Optional macro Z80_UNDOC_XY_FLAGS_EN derives undocumented flag bits 5/3 from a_in + transferred byte.
module z80_block_xfer_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        dec,
    input  logic        rpt,
    input  logic [15:0] bc_in,
    input  logic [15:0] de_in,
    input  logic [15:0] hl_in,
    input  logic [15:0] ip_in,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    z80_block_xfer_seq_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [15:0] bc_out,
    output logic [15:0] de_out,
    output logic [15:0] hl_out,
    output logic [15:0] ip_out,
    output logic [7:0]  f_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_T1, S_RD_T2, S_RD_T3, S_WR_T1, S_WR_T2, S_WR_T3,
        S_EXT1, S_EXT2, S_INT1, S_INT2, S_INT3, S_INT4, S_INT5, S_DONE
    } state_t;

    state_t      state_reg, state_next;

    logic        dec_reg, rpt_reg;
    logic [15:0] bc_reg, de_reg, hl_reg, ip_reg;
    logic [7:0]  f_reg, data_reg;
    logic [15:0] bc_calc_reg, de_calc_reg, hl_calc_reg;
    logic [15:0] mem_addr_reg;
    logic        mem_rd_reg, mem_wr_reg;
    logic        rd_next, wr_next, repeat_take;
    logic [7:0]  f_calc;

    assign repeat_take = rpt_reg && (bc_calc_reg != 16'h0000);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (start) state_next = S_RD_T1;
            S_RD_T1: state_next = S_RD_T2;
            S_RD_T2: if (!bus.mem_wait) state_next = S_RD_T3;
            S_RD_T3: state_next = S_WR_T1;
            S_WR_T1: state_next = S_WR_T2;
            S_WR_T2: if (!bus.mem_wait) state_next = S_WR_T3;
            S_WR_T3: state_next = S_EXT1;
            S_EXT1:  state_next = S_EXT2;
            S_EXT2:  state_next = repeat_take ? S_INT1 : S_DONE;
            S_INT1:  state_next = S_INT2;
            S_INT2:  state_next = S_INT3;
            S_INT3:  state_next = S_INT4;
            S_INT4:  state_next = S_INT5;
            S_INT5:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are clean for the whole M-cycle.
    assign rd_next = (state_next == S_RD_T1) || (state_next == S_RD_T2) || (state_next == S_RD_T3);
    assign wr_next = (state_next == S_WR_T1) || (state_next == S_WR_T2) || (state_next == S_WR_T3);

`ifdef Z80_UNDOC_XY_FLAGS_EN
    logic [7:0] a_reg;
    logic [7:0] xy_sum;
    assign xy_sum = a_reg + data_reg;
`else
    logic unused_a;
    assign unused_a = ^a_in;
`endif

    always_comb begin
        f_calc    = f_reg;
        f_calc[4] = 1'b0;
        f_calc[1] = 1'b0;
        f_calc[2] = (bc_calc_reg != 16'h0000);
`ifdef Z80_UNDOC_XY_FLAGS_EN
        f_calc[3] = xy_sum[3];
        f_calc[5] = xy_sum[1];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            dec_reg      <= 1'b0;
            rpt_reg      <= 1'b0;
            bc_reg       <= 16'h0000;
            de_reg       <= 16'h0000;
            hl_reg       <= 16'h0000;
            ip_reg       <= 16'h0000;
            f_reg        <= 8'h00;
            data_reg     <= 8'h00;
            bc_calc_reg  <= 16'h0000;
            de_calc_reg  <= 16'h0000;
            hl_calc_reg  <= 16'h0000;
            mem_addr_reg <= 16'h0000;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            bc_out       <= 16'h0000;
            de_out       <= 16'h0000;
            hl_out       <= 16'h0000;
            ip_out       <= 16'h0000;
            f_out        <= 8'h00;
`ifdef Z80_UNDOC_XY_FLAGS_EN
            a_reg        <= 8'h00;
`endif
        end else begin
            state_reg  <= state_next;
            mem_rd_reg <= rd_next;
            mem_wr_reg <= wr_next;

            if (state_reg == S_IDLE && start) begin
                dec_reg      <= dec;
                rpt_reg      <= rpt;
                bc_reg       <= bc_in;
                de_reg       <= de_in;
                hl_reg       <= hl_in;
                ip_reg       <= ip_in;
                f_reg        <= f_in;
                mem_addr_reg <= hl_in;
`ifdef Z80_UNDOC_XY_FLAGS_EN
                a_reg        <= a_in;
`endif
            end

            if (state_reg == S_RD_T3) begin
                data_reg     <= bus.mem_rdata;
                mem_addr_reg <= de_reg;
            end

            if (state_reg == S_EXT1) begin
                bc_calc_reg <= bc_reg - 16'd1;
                hl_calc_reg <= dec_reg ? hl_reg - 16'd1 : hl_reg + 16'd1;
                de_calc_reg <= dec_reg ? de_reg - 16'd1 : de_reg + 16'd1;
            end

            // Results become visible together with the done pulse and hold until the next one.
            if (state_next == S_DONE) begin
                bc_out <= bc_calc_reg;
                de_out <= de_calc_reg;
                hl_out <= hl_calc_reg;
                ip_out <= repeat_take ? ip_reg : ip_reg + 16'd2;
                f_out  <= f_calc;
            end
        end
    end

    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_rd    = mem_rd_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign bus.mem_wdata = data_reg;

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_z80_block_xfer_seq.sv
// Directed bench for z80_block_xfer_seq: timing, results, waits, wrap-around, reset and flags.
module tb_z80_block_xfer_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        dec = 1'b0;
    logic        rpt = 1'b0;
    logic [15:0] bc_in = 16'h0, de_in = 16'h0, hl_in = 16'h0, ip_in = 16'h0;
    logic [7:0]  a_in = 8'h0, f_in = 8'h0;
    logic        busy, done;
    logic [15:0] bc_out, de_out, hl_out, ip_out;
    logic [7:0]  f_out;

    z80_block_xfer_seq_if bus();

    logic [7:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];

    z80_block_xfer_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .dec     (dec),
        .rpt     (rpt),
        .bc_in   (bc_in),
        .de_in   (de_in),
        .hl_in   (hl_in),
        .ip_in   (ip_in),
        .a_in    (a_in),
        .f_in    (f_in),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .bc_out  (bc_out),
        .de_out  (de_out),
        .hl_out  (hl_out),
        .ip_out  (ip_out),
        .f_out   (f_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int start_cyc, latency, rd_cycles, wr_cycles, addr_changes;
    logic [15:0] wr_addr_seen;
    logic [7:0]  wr_data_seen;
    logic [7:0]  exp_f;

    task automatic start_instr(input logic d, input logic r, input logic [15:0] bc, input logic [15:0] de,
                               input logic [15:0] hl, input logic [15:0] ip, input logic [7:0] a, input logic [7:0] f);
        @(negedge clk);
        dec = d; rpt = r; bc_in = bc; de_in = de; hl_in = hl; ip_in = ip; a_in = a; f_in = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        latency = 0; rd_cycles = 0; wr_cycles = 0; addr_changes = 0;
        wr_addr_seen = 16'h0; wr_data_seen = 8'h0;
    endtask

    // Watches the bus each negedge, injects wait states and measures start-to-done latency.
    task automatic wait_done(input int rd_waits, input int wr_waits);
        int kind, prev_kind;
        logic [15:0] prev_addr;
        logic [7:0]  prev_wdata;
        prev_kind = 0; prev_addr = 16'h0; prev_wdata = 8'h0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) begin
                latency = cyc - start_cyc + 1;
                bus.mem_wait = 1'b0;
                $display("xfer: latency=%0d rd=%0d wr=%0d wr_addr=%h wr_data=%h bc=%h de=%h hl=%h ip=%h f=%h",
                         latency, rd_cycles, wr_cycles, wr_addr_seen, wr_data_seen, bc_out, de_out, hl_out, ip_out, f_out);
                return;
            end
            kind = bus.mem_rd ? 1 : (bus.mem_wr ? 2 : 0);
            if (bus.mem_rd && bus.mem_wr) addr_changes++;
            if (kind != 0 && kind == prev_kind &&
                (bus.mem_addr != prev_addr || (kind == 2 && bus.mem_wdata != prev_wdata)))
                addr_changes++;
            prev_kind = kind; prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata;
            bus.mem_wait = 1'b0;
            if (kind == 1) begin
                rd_cycles++;
                if (rd_cycles >= 2 && rd_waits > 0) begin bus.mem_wait = 1'b1; rd_waits--; end
            end
            if (kind == 2) begin
                wr_cycles++;
                wr_addr_seen = bus.mem_addr;
                wr_data_seen = bus.mem_wdata;
                if (wr_cycles >= 2 && wr_waits > 0) begin bus.mem_wait = 1'b1; wr_waits--; end
            end
        end
        bus.mem_wait = 1'b0;
        $display("FAIL timeout waiting for done got=busy want=done");
        total++; bad++;
    endtask

    task automatic test_reset;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin bad++;
            $display("FAIL reset_strobes got=%b%b want=00", bus.mem_rd, bus.mem_wr); end
        total++; if ({bc_out, de_out, hl_out, ip_out, f_out} !== 72'h0) begin bad++;
            $display("FAIL reset_outputs got=%h want=0", {bc_out, de_out, hl_out, ip_out, f_out}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ldd;
        mem[16'h2000] = 8'h5A;
        start_instr(1'b1, 1'b0, 16'h0001, 16'h3000, 16'h2000, 16'h0100, 8'h10, 8'h00);
        wait_done(0, 0);
`ifdef Z80_UNDOC_XY_FLAGS_EN
        exp_f = 8'h28;
`else
        exp_f = 8'h00;
`endif
        total++; if (latency !== 9) begin bad++; $display("FAIL ldd_latency got=%0d want=9", latency); end
        total++; if (rd_cycles !== 3 || wr_cycles !== 3) begin bad++;
            $display("FAIL ldd_mcycles got=%0d/%0d want=3/3", rd_cycles, wr_cycles); end
        total++; if (wr_addr_seen !== 16'h3000 || wr_data_seen !== 8'h5A) begin bad++;
            $display("FAIL ldd_write got=%h:%h want=3000:5a", wr_addr_seen, wr_data_seen); end
        total++; if (bc_out !== 16'h0000) begin bad++; $display("FAIL ldd_bc got=%h want=0000", bc_out); end
        total++; if (hl_out !== 16'h1FFF) begin bad++; $display("FAIL ldd_hl got=%h want=1fff", hl_out); end
        total++; if (de_out !== 16'h2FFF) begin bad++; $display("FAIL ldd_de got=%h want=2fff", de_out); end
        total++; if (ip_out !== 16'h0102) begin bad++; $display("FAIL ldd_ip got=%h want=0102", ip_out); end
        total++; if (f_out !== exp_f) begin bad++; $display("FAIL ldd_f got=%h want=%h", f_out, exp_f); end
        repeat (3) @(negedge clk);
        total++; if (hl_out !== 16'h1FFF || busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL ldd_hold got=%h/%b/%b want=1fff/0/0", hl_out, busy, done); end
    endtask

    task automatic test_ldir;
        mem[16'h1000] = 8'h77;
        start_instr(1'b0, 1'b1, 16'h0003, 16'h4000, 16'h1000, 16'h0200, 8'h00, 8'h00);
        wait_done(0, 0);
`ifdef Z80_UNDOC_XY_FLAGS_EN
        exp_f = 8'h24;
`else
        exp_f = 8'h04;
`endif
        total++; if (latency !== 14) begin bad++; $display("FAIL ldir_latency got=%0d want=14", latency); end
        total++; if (wr_addr_seen !== 16'h4000 || wr_data_seen !== 8'h77) begin bad++;
            $display("FAIL ldir_write got=%h:%h want=4000:77", wr_addr_seen, wr_data_seen); end
        total++; if (bc_out !== 16'h0002) begin bad++; $display("FAIL ldir_bc got=%h want=0002", bc_out); end
        total++; if (hl_out !== 16'h1001 || de_out !== 16'h4001) begin bad++;
            $display("FAIL ldir_hl_de got=%h/%h want=1001/4001", hl_out, de_out); end
        total++; if (ip_out !== 16'h0200) begin bad++; $display("FAIL ldir_ip got=%h want=0200", ip_out); end
        total++; if (f_out !== exp_f) begin bad++; $display("FAIL ldir_f got=%h want=%h", f_out, exp_f); end
    endtask

    task automatic test_wait;
        mem[16'h5555] = 8'hC3;
        start_instr(1'b0, 1'b0, 16'h0010, 16'h6666, 16'h5555, 16'hFFFF, 8'h00, 8'hC1);
        wait_done(2, 1);
`ifdef Z80_UNDOC_XY_FLAGS_EN
        exp_f = 8'hE5;
`else
        exp_f = 8'hC5;
`endif
        total++; if (latency !== 12) begin bad++; $display("FAIL wait_latency got=%0d want=12", latency); end
        total++; if (rd_cycles !== 5 || wr_cycles !== 4) begin bad++;
            $display("FAIL wait_mcycles got=%0d/%0d want=5/4", rd_cycles, wr_cycles); end
        total++; if (addr_changes !== 0) begin bad++;
            $display("FAIL wait_addr_stable got=%0d want=0", addr_changes); end
        total++; if (wr_addr_seen !== 16'h6666 || wr_data_seen !== 8'hC3) begin bad++;
            $display("FAIL wait_write got=%h:%h want=6666:c3", wr_addr_seen, wr_data_seen); end
        total++; if ({bc_out, hl_out, de_out} !== {16'h000F, 16'h5556, 16'h6667}) begin bad++;
            $display("FAIL wait_regs got=%h/%h/%h want=000f/5556/6667", bc_out, hl_out, de_out); end
        total++; if (ip_out !== 16'h0001) begin bad++; $display("FAIL wait_ip got=%h want=0001", ip_out); end
        total++; if (f_out !== exp_f) begin bad++; $display("FAIL wait_f got=%h want=%h", f_out, exp_f); end
    endtask

    task automatic test_wrap;
        mem[16'h0000] = 8'h11;
        start_instr(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 8'h00, 8'h00);
        wait_done(0, 0);
        total++; if (latency !== 14) begin bad++; $display("FAIL wrap_latency got=%0d want=14", latency); end
        total++; if ({bc_out, hl_out, de_out} !== {16'hFFFF, 16'hFFFF, 16'hFFFF}) begin bad++;
            $display("FAIL wrap_regs got=%h/%h/%h want=ffff/ffff/ffff", bc_out, hl_out, de_out); end
        total++; if (ip_out !== 16'h1234) begin bad++; $display("FAIL wrap_ip got=%h want=1234", ip_out); end
        total++; if (f_out !== 8'h04) begin bad++; $display("FAIL wrap_f got=%h want=04", f_out); end
    endtask

    task automatic test_reset_mid;
        int guard;
        mem[16'h0A00] = 8'h42;
        start_instr(1'b0, 1'b0, 16'h0005, 16'h0B00, 16'h0A00, 16'h0050, 8'h00, 8'h00);
        guard = 0;
        wr_cycles = 0;
        while (wr_cycles < 2 && guard < 30) begin
            @(negedge clk);
            if (bus.mem_wr) wr_cycles++;
            guard++;
        end
        total++; if (wr_cycles !== 2) begin bad++; $display("FAIL rstmid_reach_wr_t2 got=%0d want=2", wr_cycles); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL rstmid_wr_drop got=%b want=0", bus.mem_wr); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL rstmid_busy_done got=%b/%b want=0/0", busy, done); end
        total++; if ({bc_out, de_out, hl_out, ip_out, f_out} !== 72'h0) begin bad++;
            $display("FAIL rstmid_outputs got=%h want=0", {bc_out, de_out, hl_out, ip_out, f_out}); end
        @(negedge clk);
        reset_n = 1'b1;
        start_instr(1'b0, 1'b0, 16'h0005, 16'h0B00, 16'h0A00, 16'h0050, 8'h00, 8'h00);
        wait_done(0, 0);
        total++; if (latency !== 9) begin bad++; $display("FAIL rstmid_rerun_latency got=%0d want=9", latency); end
        total++; if ({bc_out, hl_out, de_out, ip_out} !== {16'h0004, 16'h0A01, 16'h0B01, 16'h0052}) begin bad++;
            $display("FAIL rstmid_rerun_regs got=%h/%h/%h/%h want=0004/0a01/0b01/0052", bc_out, hl_out, de_out, ip_out); end
        total++; if (wr_data_seen !== 8'h42) begin bad++; $display("FAIL rstmid_rerun_data got=%h want=42", wr_data_seen); end
    endtask

    task automatic test_busy_start;
        int extra;
        mem[16'h0300] = 8'h99;
        start_instr(1'b0, 1'b0, 16'h0002, 16'h0400, 16'h0300, 16'h0010, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        dec = 1'b1; rpt = 1'b1; bc_in = 16'h00AA; hl_in = 16'h0AAA; de_in = 16'h0BBB; ip_in = 16'h7777;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, 0);
        total++; if (latency !== 9) begin bad++; $display("FAIL busystart_latency got=%0d want=9", latency); end
        total++; if ({bc_out, hl_out, de_out, ip_out} !== {16'h0001, 16'h0301, 16'h0401, 16'h0012}) begin bad++;
            $display("FAIL busystart_regs got=%h/%h/%h/%h want=0001/0301/0401/0012", bc_out, hl_out, de_out, ip_out); end
        total++; if (wr_addr_seen !== 16'h0400 || wr_data_seen !== 8'h99) begin bad++;
            $display("FAIL busystart_write got=%h:%h want=0400:99", wr_addr_seen, wr_data_seen); end
        extra = 0;
        repeat (16) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL busystart_no_second got=%0d want=0", extra); end
    endtask

    task automatic test_flags;
        mem[16'h0800] = 8'h3A;
        start_instr(1'b1, 1'b0, 16'h0001, 16'h0900, 16'h0800, 16'h0000, 8'h10, 8'hFF);
        wait_done(0, 0);
        total++; if (f_out !== 8'hE9) begin bad++; $display("FAIL flags_ff got=%h want=e9", f_out); end
        start_instr(1'b1, 1'b0, 16'h0001, 16'h0900, 16'h0800, 16'h0000, 8'h10, 8'h00);
        wait_done(0, 0);
`ifdef Z80_UNDOC_XY_FLAGS_EN
        exp_f = 8'h28;
`else
        exp_f = 8'h00;
`endif
        total++; if (f_out !== exp_f) begin bad++; $display("FAIL flags_00 got=%h want=%h", f_out, exp_f); end
    endtask

    initial begin
        bus.mem_wait = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ldd();
        test_ldir();
        test_wait();
        test_wrap();
        test_reset_mid();
        test_busy_start();
        test_flags();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_block_xfer_seq.md
# z80_block_xfer_seq

Execution sequencer for the Z80 block-transfer group (LDI, LDD, LDIR, LDDR), covering everything after the two opcode-fetch M1 cycles. The core's decoder hands over a started instruction plus register state. The block performs the memory read and write M-cycles, the two extended T-states and the optional repeat internal cycle, then returns updated BC/DE/HL/F/IP. Its results and cycle sequence must match the z80fi block-transfer instruction specs exactly.

## Interface
- No parameters.
- clk  in  1  core clock, one T-state per clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin instruction (ignored while busy)
- dec  in  1  0 = increment HL/DE (LDI/LDIR), 1 = decrement (LDD/LDDR)
- rpt  in  1  repeat form (LDIR/LDDR)
- bc_in, de_in, hl_in, ip_in  in  16 each  register values sampled on start
- a_in, f_in  in  8 each  accumulator and flags sampled on start
- mem_addr  out  16  bus address
- mem_rd, mem_wr  out  1 each  read / write strobes
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data
- mem_wait  in  1  wait request, sampled in T2
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse
- bc_out, de_out, hl_out, ip_out  out  16 each  results
- f_out  out  8  result flags

## Operation
- States: IDLE, RD_T1, RD_T2, RD_T3, WR_T1, WR_T2, WR_T3, EXT1, EXT2, INT1..INT5, DONE.
- IDLE: on start, latch all inputs and go to RD_T1. busy is high in every state except IDLE.
- RD_T1..RD_T3:
  - mem_addr = HL_latched; mem_rd = 1.
  - RD_T2 repeats while mem_wait = 1.
  - The data byte is captured from mem_rdata on the RD_T3 clock edge.
- WR_T1..WR_T3:
  - mem_addr = DE_latched; mem_wr = 1; mem_wdata = captured byte.
  - WR_T2 repeats while mem_wait = 1.
- EXT1, EXT2: no bus activity.
- Results computed in EXT1:
  - BC' = BC − 1, 16-bit modulo, so BC = 0x0000 gives 0xFFFF.
  - HL' = HL ± 1 and DE' = DE ± 1, both modulo 2^16.
- From EXT2:
  - If rpt and BC' ≠ 0: go to INT1..INT5 (5 internal clocks), then DONE.
  - Otherwise go to DONE.
- IP result:
  - ip_out = ip_in + 2 when the instruction is not repeating.
  - ip_out = ip_in when it repeats, so the core re-fetches the same instruction.
- f_out:
  - H (bit 4) = 0, N (bit 1) = 0, P/V (bit 2) = (BC' ≠ 0).
  - S, Z and C are unchanged.
  - Bits 5 and 3 are set per Configuration.
- DONE: done = 1 for one clock, then IDLE.
- Outputs hold their last values until the next DONE.
- start during busy is ignored; no queueing.

## Timing
- Reset values: all registered outputs are 0; state = IDLE; mem_rd = mem_wr = 0.
- Reset is asynchronous. Asserting it mid-instruction drops the strobes immediately and abandons the instruction; no done pulse is produced.
- Latency from the start edge to the done-high cycle, with zero waits:
  - Non-repeating: 9 clocks (8 busy T-states: 3 + 3 + 2, then DONE).
  - Repeating: 14 clocks (13 T-states, then DONE).
- Each wait state adds exactly 1 clock.
- mem_addr and the strobes are registered and stable for the whole M-cycle, including waits.
- mem_wdata is valid for all of WR_T1..WR_T3.
- No strobe is active outside the RD and WR states.

## Configuration
- Z80_UNDOC_XY_FLAGS_EN defined:
  - Let n = a_in + captured byte (8-bit).
  - f_out bit 3 = n[3]; f_out bit 5 = n[1].
- Not defined:
  - f_out bits 5 and 3 pass through from f_in.
  - a_in is unused.

## Test plan
- LDD, BC=0x0001, HL=0x2000, DE=0x3000, mem[0x2000]=0x5A:
  - Write of 0x5A to 0x3000.
  - HL=0x1FFF, DE=0x2FFF, BC=0x0000, P/V=0, H=N=0.
  - ip_out = ip_in + 2; done on clock 9.
- LDIR, BC=0x0003, HL=0x1000, DE=0x4000:
  - BC=0x0002, P/V=1, ip_out = ip_in.
  - INT states are visited; done on clock 14.
- LDI with mem_wait held high for 2 clocks in RD_T2 and 1 clock in WR_T2:
  - done on clock 12.
  - mem_addr stable through every wait.
- Wrap-around: LDDR with HL=0x0000, DE=0x0000, BC=0x0000:
  - HL=0xFFFF, DE=0xFFFF, BC=0xFFFF, P/V=1, repeat taken.
- Reset asserted in WR_T2:
  - mem_wr falls without waiting for a clock edge; outputs are 0.
  - A new start after release runs normally.
  - A start pulsed while busy has no effect.
- Flags with macro, a_in=0x10, byte=0x3A:
  - n = 0x4A, giving bit 3 = 1 and bit 5 = 1.
- Same flags case without macro, f_in=0xFF:
  - LDD with BC=0x0001 gives f_out = 0xE9.
